core_bus_arbiter: RTL and testbench

CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

---
 rtl/core_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 30 +++
 rtl/core_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_core_bus_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_arb_pkg.sv
// rtl/core_arb_pkg.sv - shared defaults, FSM state type and error data for core_bus_arbiter
package core_arb_pkg;

   localparam int DEF_NUM_CORES      = 32;
   localparam int DEF_ADDR_W         = 32;
   localparam int DEF_DATA_W         = 32;
   localparam int DEF_TIMEOUT_CYCLES = 255;

   localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin winner select: first unmasked request at or after the pointer
module rr_picker #(
   parameter int N     = 32,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   input  logic [N-1:0]     mask_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [N-1:0] eligible;
   int           cand;

   always_comb begin
      eligible = req_i & ~mask_i;
      valid_o  = 1'b0;
      idx_o    = '0;
      cand     = 0;
      for (int i = 0; i < N; i++) begin
         cand = (int'(ptr_i) + i) % N;
         if (!valid_o && eligible[cand[IDX_W-1:0]]) begin
            valid_o = 1'b1;
            idx_o   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/core_bus_arbiter.sv
// rtl/core_bus_arbiter.sv - round-robin arbiter sharing one memory read port among NUM_CORES requesters
module core_bus_arbiter
   import core_arb_pkg::*;
#(
   parameter int  NUM_CORES      = DEF_NUM_CORES,
   parameter int  ADDR_W         = DEF_ADDR_W,
   parameter int  DATA_W         = DEF_DATA_W,
   parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int IDX_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [NUM_CORES-1:0]        Core_Req,
   input  logic [NUM_CORES*ADDR_W-1:0] Core_Addr,
   output logic [NUM_CORES-1:0]        Core_Ack,
   output logic [DATA_W-1:0]           Core_Data,
   output logic                        Mem_Req,
   output logic [ADDR_W-1:0]           Mem_Addr,
   input  logic                        Mem_Ack,
   input  logic [DATA_W-1:0]           Mem_Data,
   output logic [IDX_W-1:0]            Grant_Id,
   output logic                        Busy,
   output logic                        Timeout_Err
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mask_vld_q, mask_vld_d;

   logic [NUM_CORES-1:0] mask;
   logic                 pick_vld;
   logic [IDX_W-1:0]     pick_idx;

   // The core just served may still hold its request for one cycle after its Ack.
   assign mask = mask_vld_q ? (NUM_CORES'(1) << grant_q) : '0;

   rr_picker #(
      .N     (NUM_CORES),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i   (Core_Req),
      .ptr_i   (ptr_q),
      .mask_i  (mask),
      .valid_o (pick_vld),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         grant_q    <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         mask_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         mask_vld_q <= mask_vld_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      addr_d     = addr_q;
      data_d     = data_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      mask_vld_d = (state_q == ST_RESP);
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d = ST_WAIT;
               grant_d = pick_idx;
               addr_d  = Core_Addr[pick_idx*ADDR_W +: ADDR_W];
               ptr_d   = (pick_idx == IDX_W'(NUM_CORES - 1)) ? '0 : pick_idx + 1'b1;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         ST_WAIT: begin
            // A memory Ack in the last allowed cycle still counts as a normal completion.
            if (Mem_Ack) begin
               state_d = ST_RESP;
               data_d  = Mem_Data;
               err_d   = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_RESP;
               data_d  = DATA_W'(ERR_DATA);
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign Busy        = (state_q != ST_IDLE);
   assign Mem_Req     = (state_q == ST_WAIT);
   assign Mem_Addr    = Mem_Req ? addr_q : '0;
   assign Core_Ack    = (state_q == ST_RESP) ? (NUM_CORES'(1) << grant_q) : '0;
   assign Core_Data   = (state_q == ST_RESP) ? data_q : '0;
   assign Timeout_Err = (state_q == ST_RESP) && err_q;
   assign Grant_Id    = grant_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb/tb_core_bus_arbiter.sv - directed self-checking bench for core_bus_arbiter
module tb_core_bus_arbiter;

   logic          CLK = 1'b0;
   logic          RST;
   logic [31:0]   Core_Req;
   logic [1023:0] Core_Addr;
   logic [31:0]   Core_Ack;
   logic [31:0]   Core_Data;
   logic          Mem_Req;
   logic [31:0]   Mem_Addr;
   logic          Mem_Ack;
   logic [31:0]   Mem_Data;
   logic [4:0]    Grant_Id;
   logic          Busy;
   logic          Timeout_Err;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] drop1, drop2;
   logic [31:0] mem_pat;

   core_bus_arbiter dut (
      .CLK         (CLK),
      .RST         (RST),
      .Core_Req    (Core_Req),
      .Core_Addr   (Core_Addr),
      .Core_Ack    (Core_Ack),
      .Core_Data   (Core_Data),
      .Mem_Req     (Mem_Req),
      .Mem_Addr    (Mem_Addr),
      .Mem_Ack     (Mem_Ack),
      .Mem_Data    (Mem_Data),
      .Grant_Id    (Grant_Id),
      .Busy        (Busy),
      .Timeout_Err (Timeout_Err)
   );

   always #5 CLK = ~CLK;

   // Cores drop their request two cycles after Ack, exercising the post-RESP mask.
   task automatic tick();
      @(negedge CLK);
      Core_Req = Core_Req & ~drop2;
      drop2    = drop1;
      drop1    = '0;
   endtask

   task automatic idle_cycle();
      tick();
      Mem_Ack = 1'b0;
   endtask

   task automatic set_addrs();
      for (int i = 0; i < 32; i++) Core_Addr[i*32 +: 32] = 32'h1000 + 32'(i * 16);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1; Core_Req = '0; Mem_Ack = 1'b0; drop1 = '0; drop2 = '0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic serve(input int ack_delay, input int budget, output int idx,
                        output logic [31:0] data, output logic err,
                        output int waits, output int ncyc);
      int w;
      idx = -1; data = '0; err = 1'b0; waits = 0; ncyc = 0; w = 0;
      while (idx < 0 && ncyc < budget) begin
         tick();
         ncyc++;
         if (Core_Ack != '0) begin
            for (int i = 0; i < 32; i++) if (Core_Ack[i]) idx = i;
            data  = Core_Data;
            err   = Timeout_Err;
            drop1 = Core_Ack;
         end
         if (Mem_Req) begin
            w++;
            waits    = w;
            Mem_Ack  = (w == ack_delay + 1);
            Mem_Data = mem_pat ^ Mem_Addr;
         end else begin
            Mem_Ack = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      vectors++;
      if ({Mem_Req, Busy, Timeout_Err} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_ctl: got %b expected 000", {Mem_Req, Busy, Timeout_Err});
      end
      vectors++;
      if (Core_Ack !== 32'h0 || Core_Data !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_ack: got %h/%h expected 0/0", Core_Ack, Core_Data);
      end
      vectors++;
      if (Mem_Addr !== 32'h0 || Grant_Id !== 5'd0) begin
         miscompares++;
         $display("FAIL reset_addr: got %h/%0d expected 0/0", Mem_Addr, Grant_Id);
      end
   endtask

   task automatic test_single();
      Core_Addr[5*32 +: 32] = 32'h100;
      Core_Req = 32'h20;
      tick();
      vectors++;
      if (Mem_Req !== 1'b1 || Mem_Addr !== 32'h100 || Grant_Id !== 5'd5 || Busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_wait: got req=%b addr=%h gid=%0d busy=%b expected 1/100/5/1",
                  Mem_Req, Mem_Addr, Grant_Id, Busy);
      end
      tick();
      tick();
      vectors++;
      if (Core_Ack !== 32'h0 || Mem_Req !== 1'b1) begin
         miscompares++;
         $display("FAIL single_hold: got ack=%h req=%b expected 0/1", Core_Ack, Mem_Req);
      end
      tick();
      Mem_Ack = 1'b1; Mem_Data = 32'hA5A5_A5A5;
      tick();
      Mem_Ack = 1'b0;
      vectors++;
      if (Core_Ack !== 32'h20 || Core_Data !== 32'hA5A5_A5A5 || Grant_Id !== 5'd5) begin
         miscompares++;
         $display("FAIL single_ack: got ack=%h data=%h gid=%0d expected 20/a5a5a5a5/5",
                  Core_Ack, Core_Data, Grant_Id);
      end
      vectors++;
      if (Timeout_Err !== 1'b0 || Mem_Req !== 1'b0 || Mem_Addr !== 32'h0) begin
         miscompares++;
         $display("FAIL single_resp: got err=%b req=%b addr=%h expected 0/0/0",
                  Timeout_Err, Mem_Req, Mem_Addr);
      end
      Core_Req = '0;
      tick();
      vectors++;
      if (Core_Ack !== 32'h0 || Core_Data !== 32'h0 || Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_pulse: got ack=%h data=%h busy=%b expected 0/0/0",
                  Core_Ack, Core_Data, Busy);
      end
      set_addrs();
   endtask

   task automatic test_all_cores();
      int idx, waits, ncyc;
      logic [31:0] data;
      logic err;
      do_reset();
      set_addrs();
      mem_pat  = 32'hC0DE_0000;
      Core_Req = '1;
      for (int k = 0; k < 32; k++) begin
         serve(0, 10, idx, data, err, waits, ncyc);
         vectors++;
         if (idx !== k || data !== (mem_pat ^ (32'h1000 + 32'(k * 16))) || err !== 1'b0) begin
            miscompares++;
            $display("FAIL all_grant%0d: got idx=%0d data=%h err=%b expected %0d/%h/0",
                     k, idx, data, err, k, mem_pat ^ (32'h1000 + 32'(k * 16)));
         end
         vectors++;
         if (ncyc !== ((k == 0) ? 2 : 3)) begin
            miscompares++;
            $display("FAIL all_spacing%0d: got %0d expected %0d", k, ncyc, (k == 0) ? 2 : 3);
         end
      end
      idle_cycle();
      idle_cycle();
      vectors++;
      if (Busy !== 1'b0 || Mem_Req !== 1'b0) begin
         miscompares++;
         $display("FAIL all_no_dup: got busy=%b req=%b expected 0/0", Busy, Mem_Req);
      end
   endtask

   task automatic test_rr_wrap();
      int idx, waits, ncyc;
      logic [31:0] data;
      logic err;
      do_reset();
      Core_Req = 32'h1 << 29;
      serve(0, 10, idx, data, err, waits, ncyc);
      vectors++;
      if (idx !== 29) begin
         miscompares++;
         $display("FAIL wrap_first: got %0d expected 29", idx);
      end
      Core_Req = Core_Req | (32'h1 << 3) | (32'h1 << 31);
      serve(0, 10, idx, data, err, waits, ncyc);
      vectors++;
      if (idx !== 31) begin
         miscompares++;
         $display("FAIL wrap_31: got %0d expected 31", idx);
      end
      serve(0, 10, idx, data, err, waits, ncyc);
      vectors++;
      if (idx !== 3) begin
         miscompares++;
         $display("FAIL wrap_3: got %0d expected 3", idx);
      end
   endtask

   task automatic test_req_drop();
      int idx, waits, ncyc;
      logic [31:0] data;
      logic err;
      Core_Req = 32'h1 << 9;
      idle_cycle();
      idle_cycle();
      Core_Req = '0;
      serve(1, 10, idx, data, err, waits, ncyc);
      vectors++;
      if (idx !== 9 || err !== 1'b0 || data !== (mem_pat ^ 32'h1090)) begin
         miscompares++;
         $display("FAIL req_drop: got idx=%0d err=%b data=%h expected 9/0/%h",
                  idx, err, data, mem_pat ^ 32'h1090);
      end
   endtask

   task automatic test_timeout();
      int idx, waits, ncyc;
      logic [31:0] data;
      logic err;
      Core_Req = 32'h1 << 2;
      serve(1000, 400, idx, data, err, waits, ncyc);
      vectors++;
      if (idx !== 2 || data !== 32'hDEAD_BEEF || err !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_resp: got idx=%0d data=%h err=%b expected 2/deadbeef/1",
                  idx, data, err);
      end
      vectors++;
      if (waits !== 255 || Mem_Req !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_len: got waits=%0d req=%b expected 255/0", waits, Mem_Req);
      end
      idle_cycle();
      vectors++;
      if (Timeout_Err !== 1'b0 || Core_Ack !== 32'h0) begin
         miscompares++;
         $display("FAIL timeout_pulse: got err=%b ack=%h expected 0/0", Timeout_Err, Core_Ack);
      end
   endtask

   task automatic test_ack_on_last();
      int idx, waits, ncyc;
      logic [31:0] data;
      logic err;
      mem_pat  = 32'h1234_5678;
      Core_Req = 32'h1 << 6;
      serve(254, 400, idx, data, err, waits, ncyc);
      vectors++;
      if (idx !== 6 || data !== (32'h1234_5678 ^ 32'h1060) || err !== 1'b0 || waits !== 255) begin
         miscompares++;
         $display("FAIL ack_on_last: got idx=%0d data=%h err=%b waits=%0d expected 6/%h/0/255",
                  idx, data, err, waits, 32'h1234_5678 ^ 32'h1060);
      end
   endtask

   task automatic test_reset_mid();
      int idx, waits, ncyc;
      logic [31:0] data;
      logic err;
      idle_cycle();
      idle_cycle();
      Core_Req = 32'h1 << 4;
      tick();
      tick();
      vectors++;
      if (Mem_Req !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_wait: got %b expected 1", Mem_Req);
      end
      RST = 1'b1;
      tick();
      vectors++;
      if (Mem_Req !== 1'b0 || Busy !== 1'b0 || Core_Ack !== 32'h0 || Timeout_Err !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_drop: got req=%b busy=%b ack=%h err=%b expected 0/0/0/0",
                  Mem_Req, Busy, Core_Ack, Timeout_Err);
      end
      RST = 1'b0;
      drop1 = '0; drop2 = '0;
      Core_Req = (32'h1 << 0) | (32'h1 << 7);
      serve(0, 10, idx, data, err, waits, ncyc);
      vectors++;
      if (idx !== 0) begin
         miscompares++;
         $display("FAIL rstmid_first: got %0d expected 0", idx);
      end
      serve(0, 10, idx, data, err, waits, ncyc);
      vectors++;
      if (idx !== 7) begin
         miscompares++;
         $display("FAIL rstmid_second: got %0d expected 7", idx);
      end
   endtask

   task automatic test_idle_ack();
      idle_cycle();
      idle_cycle();
      idle_cycle();
      Core_Req = '0;
      Mem_Ack  = 1'b1;
      Mem_Data = 32'h5A5A_5A5A;
      tick();
      Mem_Ack = 1'b0;
      vectors++;
      if (Core_Ack !== 32'h0 || Core_Data !== 32'h0 || Busy !== 1'b0 || Mem_Req !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_ack: got ack=%h data=%h busy=%b req=%b expected 0/0/0/0",
                  Core_Ack, Core_Data, Busy, Mem_Req);
      end
      tick();
      vectors++;
      if (Core_Ack !== 32'h0 || Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_ack_after: got ack=%h busy=%b expected 0/0", Core_Ack, Busy);
      end
   endtask

   initial begin
      RST      = 1'b1;
      Core_Req = '0;
      Core_Addr = '0;
      Mem_Ack  = 1'b0;
      Mem_Data = '0;
      drop1    = '0;
      drop2    = '0;
      mem_pat  = 32'h0BAD_0000;
      set_addrs();
      test_reset();
      test_single();
      test_all_cores();
      test_rr_wrap();
      test_req_drop();
      test_timeout();
      test_ack_on_last();
      test_reset_mid();
      test_idle_ack();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
